data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised successor data memory for the MIPS datapath. It adds byte, halfword and word loads and stores, with sign or zero extension on loads. It detects misaligned and out-of-range accesses, and provides a req/done handshake with a configurable number of wait states so the pipeline can be tested against slow memory. It sits in the MEM stage between the ALU address result and the write-back mux.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; any value ≥ 1, not necessarily a power of two.
- ADDR_W, 32: width of the byte address.
- WAIT_CYCLES, 0: extra wait states per access (0..255).

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req  input  1  access request, sampled only in IDLE
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- ld_unsigned  input  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- addr  input  ADDR_W  byte address
- wdata  input  32  store data; the value sits in the low bits for byte/half
- rdata  output  32  extended load result, registered
- busy  output  1  access in progress; pipeline stalls while high
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with done

## Operation
- Storage: DEPTH × 32-bit array, initialised to 0 at time zero. Reset does not alter the contents.
- Word index is addr[ADDR_W-1:2]. The access is out-of-range if index ≥ DEPTH.
- Misaligned conditions:
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]≠00
  - size=11 is always an error.
- Byte lanes are big-endian.
  - Byte at addr[1:0]=00 occupies bits 31:24; 11 occupies bits 7:0.
  - Halfword with addr[1]=0 occupies bits 31:16.
- Store byte writes wdata[7:0] into the selected lane only. Store half writes wdata[15:0] into the selected half only. Unselected lanes keep their value.
- Load byte/half: the selected lane is right-justified, then sign-extended from bit 7/15 (ld_unsigned=0) or zero-extended (ld_unsigned=1). Load word returns the full word; ld_unsigned is ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE + req: latch we, size, ld_unsigned, addr, wdata.
    - If the access is erroneous, go to RESP with the err flag set. No write occurs and rdata is unchanged.
    - Else if WAIT_CYCLES=0, commit now and go to RESP.
    - Else go to WAIT with counter = WAIT_CYCLES-1.
  - WAIT: decrement the counter. When the counter = 0, commit and go to RESP.
  - RESP: done=1, err per flag. Always return to IDLE; req is ignored in this state.
- Commit edge, store: array write happens.
- Commit edge, load: rdata is loaded with the extended result.
- rdata holds its value until the next successful load. Stores and errors leave it unchanged.
- Inputs are don't-care outside the accepting IDLE edge. Changes to them during WAIT have no effect.

## Timing
- Reset values: state IDLE, rdata=0, busy=0, done=0, err=0, counter=0.
- Reset asserted in WAIT: the access is abandoned and no write occurs. Reset asserted in RESP: the done pulse is suppressed on the following cycle.
- Accept edge T: busy=1 from cycle T+1 up to and including the done cycle.
- done and err are high in cycle T+1+WAIT_CYCLES for a valid access, and in cycle T+1 for an erroneous one.
- rdata is valid in the done cycle.
- busy=0 in the cycle after done. A req seen there is accepted at that edge, giving minimum spacing of WAIT_CYCLES+2 cycles between accepts.
- busy is registered and done is registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then word path, WAIT_CYCLES=0: store word 0xDEADBEEF to addr 0x10, then load word from 0x10.
  - Required: done one cycle after each accept.
  - Required: rdata=0xDEADBEEF in the load's done cycle.
  - Required: busy high exactly one cycle per access.
- Byte lanes: after the above, store byte 0x7F to 0x12, then load word 0x10.
  - Required: rdata=0xDEAD7FEF.
  - Then lb 0x11 → 0xFFFFFFAD, lbu 0x11 → 0x000000AD, lh 0x10 → 0xFFFFDEAD, lhu 0x12 → 0x00007FEF.
- Errors: lw 0x13, sh 0x21, size=11 at 0x0, and lw at byte address 4×DEPTH.
  - Required: each gives done=err=1 one cycle after accept.
  - Required: rdata unchanged and memory unchanged; checked by reading back 0x20 and word index 0.
- Wait states, WAIT_CYCLES=3: accept at cycle T.
  - Required: done at T+4, busy high T+1..T+4.
  - Required: req held high continuously is re-accepted at T+5.
  - Required: wdata changed at T+2 does not affect the stored value.
- Reset mid-access, WAIT_CYCLES=3: store 0x12345678 to 0x40, assert reset at T+2.
  - Required: no done pulse and busy=0 after reset.
  - Required: a subsequent lw 0x40 returns the prior value (0).
- Back-to-back: sw then lw to the same address with req held high.
  - Required: the load returns the newly stored data.
  - Required: the second accept occurs exactly WAIT_CYCLES+2 cycles after the first.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   MEM-stage data memory for the MIPS datapath. Byte / halfword / word loads
//   and stores on a big-endian DEPTH x 32-bit array, sign or zero extension on
//   loads, misalignment and range checking, and a req/done handshake with
//   WAIT_CYCLES programmable wait states.
//
// Parameters
//   DEPTH        number of 32-bit words (>= 1, any value)
//   ADDR_W       byte address width
//   WAIT_CYCLES  extra wait states per valid access (0..255)
//
// Ports
//   clk          clock, all state on rising edge
//   reset        synchronous active-high reset (memory contents untouched)
//   req          access request, only looked at in IDLE
//   we           1 = store, 0 = load
//   size         00 byte, 01 halfword, 10 word, 11 reserved (always error)
//   ld_unsigned  1 = zero-extend byte/half loads, 0 = sign-extend
//   addr         byte address
//   wdata        store data, right-justified for byte/half
//   rdata        registered, extended load result; held until next good load
//   busy         access in progress (accept+1 .. done cycle inclusive)
//   done         one-cycle completion pulse
//   err          one-cycle error pulse, coincident with done
//   dbg_state    current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// Handshake: the block accepts an access on any rising edge where it is IDLE
// and req=1; all request inputs are captured on that edge and ignored
// afterwards. Exactly one done pulse follows every accept (unless reset
// intervenes), WAIT_CYCLES+1 cycles later for a valid access and one cycle
// later for an erroneous one. busy is high from the cycle after the accept
// through the done cycle, and req is ignored for that whole interval plus the
// cycle in which the FSM leaves RESP.
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int            IW       = ADDR_W - 2;
  localparam int            MW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable when DEPTH = 2**IW.
  localparam logic [IW:0]   DEPTH_X  = (IW + 1)'(DEPTH);
  localparam logic [7:0]    CNT_INIT = 8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  // Contents start at zero and are never touched by reset.
  logic [31:0]     r_mem [DEPTH] = '{default: '0};

  logic            r_we;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [MW-1:0]   r_idx;
  logic [1:0]      r_lane;
  logic [31:0]     r_wdata;
  logic [7:0]      r_cnt;
  logic [31:0]     r_rdata;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_idle;
  logic            w_accept;
  logic            w_req_err;
  logic            w_commit;
  logic            w_c_we;
  logic [1:0]      w_c_size;
  logic            w_c_uns;
  logic [MW-1:0]   w_c_idx;
  logic [1:0]      w_c_lane;
  logic [31:0]     w_c_wdata;
  logic [31:0]     w_cur;
  logic [31:0]     w_new;
  logic [31:0]     w_ld;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && req;

  // Error classification is done on the live inputs at the accept edge.
  assign w_req_err = (size == 2'b11)
                  || ((size == 2'b01) && addr[0])
                  || ((size == 2'b10) && (addr[1:0] != 2'b00))
                  || ({1'b0, addr[ADDR_W-1:2]} >= DEPTH_X);

  // With zero wait states the commit happens on the accept edge itself, so the
  // datapath works from the live inputs in IDLE and from the captured copy
  // while waiting.
  assign w_c_we    = w_idle ? we             : r_we;
  assign w_c_size  = w_idle ? size           : r_size;
  assign w_c_uns   = w_idle ? ld_unsigned    : r_uns;
  assign w_c_idx   = w_idle ? addr[MW+1:2]   : r_idx;
  assign w_c_lane  = w_idle ? addr[1:0]      : r_lane;
  assign w_c_wdata = w_idle ? wdata          : r_wdata;

  // Reset wins over a commit landing on the same edge: the access is dropped.
  assign w_commit = !reset
                 && ((w_accept && !w_req_err && (WAIT_CYCLES == 0))
                  || ((r_state == S_WAIT) && (r_cnt == 8'd0)));

  assign w_cur = r_mem[w_c_idx];

  // Lane merge for stores and lane extract + extension for loads.
  // Big-endian: lane 0 is bits 31:24, lane 3 is bits 7:0.
  always_comb begin
    w_new  = w_c_wdata;
    w_byte = w_cur[7:0];
    w_half = w_cur[15:0];
    w_ld   = w_cur;
    case (w_c_size)
      2'b00: begin
        case (w_c_lane)
          2'd0: begin
            w_new  = {w_c_wdata[7:0], w_cur[23:0]};
            w_byte = w_cur[31:24];
          end
          2'd1: begin
            w_new  = {w_cur[31:24], w_c_wdata[7:0], w_cur[15:0]};
            w_byte = w_cur[23:16];
          end
          2'd2: begin
            w_new  = {w_cur[31:16], w_c_wdata[7:0], w_cur[7:0]};
            w_byte = w_cur[15:8];
          end
          default: begin
            w_new  = {w_cur[31:8], w_c_wdata[7:0]};
            w_byte = w_cur[7:0];
          end
        endcase
        w_ld = w_c_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        if (w_c_lane[1]) begin
          w_new  = {w_cur[31:16], w_c_wdata[15:0]};
          w_half = w_cur[15:0];
        end else begin
          w_new  = {w_c_wdata[15:0], w_cur[15:0]};
          w_half = w_cur[31:16];
        end
        w_ld = w_c_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        w_new = w_c_wdata;
        w_ld  = w_cur;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_req_err || (WAIT_CYCLES == 0)) w_next = S_RESP;
          else                                 w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 8'd0) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control, capture and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_RESP);
      // The only transition into RESP carrying an error is straight from IDLE.
      r_err   <= w_accept && w_req_err;
      if (w_accept) begin
        r_we    <= we;
        r_size  <= size;
        r_uns   <= ld_unsigned;
        r_idx   <= addr[MW+1:2];
        r_lane  <= addr[1:0];
        r_wdata <= wdata;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_commit && !w_c_we) r_rdata <= w_ld;
    end
  end

  // Storage array, no reset
  always_ff @(posedge clk) begin
    if (w_commit && w_c_we) r_mem[w_c_idx] <= w_new;
  end

  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Two instances share the request bus: dut0 (DEPTH=40, no wait states) and
//   dut3 (DEPTH=32, three wait states). sel picks which one receives req and
//   whose outputs are observed. A byte-array reference model tracks memory
//   contents and the expected rdata for each instance.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int D0 = 40;
  localparam int D3 = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        req0, req3;
  logic [31:0] rdata0, rdata3, rdata;
  logic        busy0, busy3, busy;
  logic        done0, done3, done;
  logic        err0, err3, err;
  logic [1:0]  dbg0, dbg3;

  assign req0  = req && !sel;
  assign req3  = req && sel;
  assign rdata = sel ? rdata3 : rdata0;
  assign busy  = sel ? busy3  : busy0;
  assign done  = sel ? done3  : done0;
  assign err   = sel ? err3   : err0;

  data_memory_ctrl #(.DEPTH(D0), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .size(size),
    .ld_unsigned(uns), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .busy(busy0), .done(done0), .err(err0), .dbg_state(dbg0)
  );

  data_memory_ctrl #(.DEPTH(D3), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we), .size(size),
    .ld_unsigned(uns), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .busy(busy3), .done(done3), .err(err3), .dbg_state(dbg3)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [2][64];
  logic [31:0] mrd [2];

  function automatic int cur_s();
    return sel ? 1 : 0;
  endfunction

  function automatic int depth_of(int s);
    return (s == 1) ? D3 : D0;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic m_err(logic [31:0] a, logic [1:0] sz, int dep);
    return (sz == 2'b11) || ((sz == 2'b01) && a[0]) ||
           ((sz == 2'b10) && (a[1:0] != 2'b00)) || (int'(a >> 2) >= dep);
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] word, logic [1:0] a,
                                         logic [1:0] sz, logic u);
    logic [7:0]  b [4];
    logic [7:0]  v;
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = word[8*(3-i) +: 8];
    if (sz == 2'b00) begin
      v = b[a];
      return u ? {24'd0, v} : {{24{v[7]}}, v};
    end else if (sz == 2'b01) begin
      h = {b[a], b[a + 2'd1]};
      return u ? {16'd0, h} : {{16{h[15]}}, h};
    end
    return word;
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] word, logic [1:0] a,
                                          logic [1:0] sz, logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = word[8*(3-i) +: 8];
    if (sz == 2'b00) begin
      b[a] = d[7:0];
    end else if (sz == 2'b01) begin
      b[a]        = d[15:8];
      b[a + 2'd1] = d[7:0];
    end else begin
      return d;
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // ---------------- driver: one complete access ----------------
  task automatic access(input string name, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd_o);
    int          s        = cur_s();
    int          wc       = sel ? 3 : 0;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rd;
    int          lat      = 0;
    int          busy_n   = 0;
    logic        got      = 1'b0;
    logic        got_err  = 1'b0;
    logic [31:0] got_rd   = 32'd0;
    int          wi;

    exp_err = m_err(a, sz, depth_of(s));
    wi      = int'(a >> 2);
    if (!exp_err) begin
      if (w) mdl[s][wi] = m_store(mdl[s][wi], a[1:0], sz, d);
      else   mrd[s]     = m_load(mdl[s][wi], a[1:0], sz, u);
    end
    exp_rd  = mrd[s];
    exp_lat = exp_err ? 1 : wc + 1;

    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        got = 1'b1; lat = c; got_err = err; got_rd = rdata;
      end
    end
    rd_o = got_rd;

    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: got no done, want done after %0d cycles", name, exp_lat);
    end else begin
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (got_err !== exp_err) begin
        errors++;
        $display("FAIL %s err: got %0b want %0b", name, got_err, exp_err);
      end
      checks++;
      if (got_rd !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata: got %08h want %08h", name, got_rd, exp_rd);
      end
      checks++;
      if (busy_n !== exp_lat) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, exp_lat);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL %s after_done: got busy=%0b done=%0b want 0 0", name, busy, done);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdata0, busy0, done0, err0} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut0: got rdata=%08h busy=%0b done=%0b err=%0b want all 0",
               rdata0, busy0, done0, err0);
    end
    checks++;
    if ({rdata3, busy3, done3, err3} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut3: got rdata=%08h busy=%0b done=%0b err=%0b want all 0",
               rdata3, busy3, done3, err3);
    end
    reset = 1'b0;
  endtask

  task automatic test_word_path();
    logic [31:0] rd;
    sel = 1'b0;
    access("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    access("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_path_const: got %08h want DEADBEEF", rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic [31:0] want [5] = '{32'hDEAD7FEF, 32'hFFFFFFAD, 32'h000000AD,
                              32'hFFFFDEAD, 32'h00007FEF};
    logic [1:0]  sz   [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        un   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad   [5] = '{32'h10, 32'h11, 32'h11, 32'h10, 32'h12};
    sel = 1'b0;
    // Upper bits of wdata must not leak into neighbouring lanes.
    access("sb_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'hA5A5A57F, rd);
    for (int i = 0; i < 5; i++) begin
      access($sformatf("lane_ld%0d", i), 1'b0, sz[i], un[i], ad[i], 32'h0, rd);
      checks++;
      if (rd !== want[i]) begin
        errors++;
        $display("FAIL lane_const%0d: got %08h want %08h", i, rd, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic [31:0] v20 = $urandom;
    logic [31:0] v00 = $urandom;
    sel = 1'b0;
    access("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, v20, rd);
    access("sw_00", 1'b1, 2'b10, 1'b0, 32'h00, v00, rd);
    access("lw_20_pre", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
    access("err_lw_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd);
    access("err_sh_21", 1'b1, 2'b01, 1'b0, 32'h21, $urandom, rd);
    access("err_sz11", 1'b1, 2'b11, 1'b0, 32'h0, $urandom, rd);
    access("err_oob_lw", 1'b0, 2'b10, 1'b0, 32'(4 * D0), 32'h0, rd);
    access("err_oob_sw", 1'b1, 2'b10, 1'b0, 32'(4 * D0 + 4), $urandom, rd);
    access("lw_20_post", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
    checks++;
    if (rd !== v20) begin
      errors++;
      $display("FAIL err_mem20: got %08h want %08h", rd, v20);
    end
    access("lw_00_post", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd);
    checks++;
    if (rd !== v00) begin
      errors++;
      $display("FAIL err_mem00: got %08h want %08h", rd, v00);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] x = $urandom;
    logic        exp_busy, exp_done;
    sel = 1'b1;
    @(negedge clk);
    we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h8; wdata = x; req = 1'b1;
    @(posedge clk);                       // accept edge T
    mdl[1][2] = x;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);                     // cycle T+k
      exp_busy = (k <= 4) || (k >= 6);
      exp_done = (k == 4) || (k == 9);
      checks++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL wait_cycle%0d: got busy=%0b done=%0b want busy=%0b done=%0b",
                 k, busy, done, exp_busy, exp_done);
      end
      if (k == 2) wdata = ~x;
      if (k == 4) we = 1'b0;              // re-accept at T+5 will be lw 0x8
      if (k == 6) req = 1'b0;
      if (k == 9) begin
        mrd[1] = x;
        checks++;
        if ({err, rdata} !== {1'b0, x}) begin
          errors++;
          $display("FAIL wait_rdata: got err=%0b rdata=%08h want err=0 rdata=%08h",
                   err, rdata, x);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          seen = 0;
    sel = 1'b1;
    @(negedge clk);
    we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'h12345678; req = 1'b1;
    @(posedge clk);                       // accept edge T
    @(negedge clk);                       // cycle T+1
    req = 1'b0;
    @(negedge clk);                       // cycle T+2
    reset = 1'b1;
    @(negedge clk);                       // cycle T+3, reset sampled at edge T+2
    reset = 1'b0;
    mrd[0] = 32'd0;
    mrd[1] = 32'd0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_state: got busy=%0b done=%0b want 0 0", busy, done);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d active cycles want 0", seen);
    end
    access("rst_mid_lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_mem: got %08h want 00000000", rd);
    end
  endtask

  task automatic test_back_to_back(input logic s_in);
    int          s;
    int          wc;
    logic [31:0] d = $urandom;
    logic [31:0] a;
    logic        got = 1'b0;
    sel = s_in;
    s   = cur_s();
    wc  = s_in ? 3 : 0;
    a   = {$urandom_range(0, depth_of(s) - 1), 2'b00};
    @(negedge clk);
    we = 1'b1; size = 2'b10; uns = 1'b0; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);                       // first accept, edge T
    mdl[s][int'(a >> 2)] = d;
    mrd[s] = d;
    for (int k = 1; k <= wc + 1; k++) begin
      @(negedge clk);
      if (k == wc + 1) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL b2b%0d_sw_done: got %0b want 1", wc, done);
        end
        we = 1'b0;
      end
    end
    @(negedge clk);                       // cycle T+wc+2: idle, req still high
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b%0d_gap: got busy=%0b want 0", wc, busy);
    end
    @(negedge clk);                       // cycle T+wc+3: second access running
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b%0d_spacing: got busy=%0b want 1", wc, busy);
    end
    for (int c = 0; c < 10 && !got; c++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || rdata !== d) begin
      errors++;
      $display("FAIL b2b%0d_load: got done=%0b rdata=%08h want done=1 rdata=%08h",
               wc, got, rdata, d);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      sel = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom_range(0, 4 * depth_of(cur_s()) + 7);
      // Steer most accesses to aligned addresses so valid traffic dominates.
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz,
             1'($urandom_range(0, 1)), a, $urandom, rd);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int s = 0; s < 2; s++) begin
      mrd[s] = 32'd0;
      for (int i = 0; i < 64; i++) mdl[s][i] = 32'd0;
    end
    test_reset();
    test_word_path();
    test_byte_lanes();
    test_errors();
    test_wait_states();
    test_reset_mid();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish before 400000");
    $fatal(1);
  end

endmodule
